// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   state_t / ST_*  : frame sequencer state encoding (3-bit, legacy-compatible constants)
//   PS_*            : supported oversampling ratios
//   sel_ps()        : maps a raw pre_scale value onto a supported ratio (8 is the fallback)
//   check_edge()    : oversample index at which the majority-voted bit value is valid
package uart_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam logic [5:0] PS_8  = 6'd8;
  localparam logic [5:0] PS_16 = 6'd16;
  localparam logic [5:0] PS_32 = 6'd32;

  function automatic logic [5:0] sel_ps(input logic [5:0] pre_scale);
    if (pre_scale == PS_16)      return PS_16;
    else if (pre_scale == PS_32) return PS_32;
    else                         return PS_8;
  endfunction

  // The sampler votes over edges ps/2-1..ps/2+1, so its result is settled two
  // edges past mid-bit.
  function automatic logic [5:0] check_edge(input logic [5:0] ps);
    return (ps >> 1) + 6'd2;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge / bit counters for the UART receive frame sequencer.
//   clk, rst_n : oversampling clock, async active-low reset
//   cnt_en     : advance the counters this cycle
//   clr        : force both counters to 0 (wins over cnt_en)
//   load       : latch the frame's oversampling ratio from pre_scale
//   pre_scale  : raw oversampling ratio input
//   ps         : latched (supported) ratio for the current frame
//   edge_cnt   : oversample index within the current bit, 0..ps-1
//   bit_cnt    : bit index within the frame
//   last       : edge_cnt is at the final oversample of the bit
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_en,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] pre_scale,
  output logic [5:0] ps,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       last
);

  assign last = (edge_cnt == ps - 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps       <= PS_8;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load) ps <= sel_ps(pre_scale);
      if (clr) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (cnt_en) begin
        if (last) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer for the UART receiver datapath: start detection, bit timing,
// checker enables and per-frame status.
//   clk, rst_n       : oversampling clock, async active-low reset
//   RX_IN            : synchronized serial line, idle high
//   pre_scale        : oversampling ratio (8/16/32; others behave as 8), latched per frame
//   par_en           : parity bit present, latched per frame
//   strt_glitch      : start checker result, valid while strt_chk_en is high
//   par_err          : parity checker result, valid while par_chk_en is high
//   stp_err          : stop checker result, valid while stp_chk_en is high
//   dat_samp_en/busy : high in every state except IDLE
//   edge_cnt/bit_cnt : oversample index / bit index
//   *_chk_en/deser_en: one-cycle pulses at the check edge of the matching bit
//   data_valid, parity_error, framing_error : one-cycle frame status in DONE
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX_IN,
  input  logic [5:0] pre_scale,
  input  logic       par_en,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       strt_chk_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  state_t     state, state_nxt;
  logic [5:0] ps, ce, ce_m1;
  logic       last, cnt_en, clr, load;
  logic       par_q, par_flag;

  assign ce    = check_edge(ps);
  assign ce_m1 = ce - 6'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
      ST_START: begin
        // Check enables are registered and land exactly on the check edge,
        // so they double as the "decide now" qualifiers.
        if (strt_chk_en && strt_glitch) state_nxt = ST_IDLE;
        else if (last)                  state_nxt = ST_DATA;
      end
      ST_DATA:   if (last && bit_cnt == 4'(DATA_WIDTH))
                   state_nxt = par_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (last) state_nxt = ST_STOP;
      // Leave mid stop bit so a following start edge is not missed.
      ST_STOP:   if (stp_chk_en) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = RX_IN ? ST_IDLE : ST_START;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign cnt_en = (state != ST_IDLE) && (state != ST_DONE);
  assign clr    = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
  assign load   = (state_nxt == ST_START) && ((state == ST_IDLE) || (state == ST_DONE));

  uart_rx_edge_bit_cnt u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_en    (cnt_en),
    .clr       (clr),
    .load      (load),
    .pre_scale (pre_scale),
    .ps        (ps),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      par_q         <= 1'b0;
      par_flag      <= 1'b0;
      busy          <= 1'b0;
      dat_samp_en   <= 1'b0;
      strt_chk_en   <= 1'b0;
      deser_en      <= 1'b0;
      par_chk_en    <= 1'b0;
      stp_chk_en    <= 1'b0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      dat_samp_en <= (state_nxt != ST_IDLE);
      if (load) par_q <= par_en;

      // Raised one edge early so the registered pulse coincides with edge CE.
      // CE-1 is never the wrap edge, so the state is the same on both cycles.
      strt_chk_en <= (state == ST_START)  && (edge_cnt == ce_m1);
      deser_en    <= (state == ST_DATA)   && (edge_cnt == ce_m1);
      par_chk_en  <= (state == ST_PARITY) && (edge_cnt == ce_m1);
      stp_chk_en  <= (state == ST_STOP)   && (edge_cnt == ce_m1);

      if ((state == ST_IDLE) || (state == ST_DONE)) par_flag <= 1'b0;
      else if (par_chk_en)                          par_flag <= par_flag | par_err;

      // Status is decided on the stop check edge and shows in the DONE cycle.
      data_valid    <= stp_chk_en && !(par_flag || stp_err);
      parity_error  <= stp_chk_en && par_flag;
      framing_error <= stp_chk_en && stp_err;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized self-checking bench for uart_rx_frame_ctrl. The reference model
// tracks only "cycles since the first START cycle" plus the frame's latched
// configuration, and derives every expected output arithmetically from that.
module tb_uart_rx_frame_ctrl;

  localparam int DW   = 8;
  localparam int NCYC = 5000;

  logic       clk = 1'b0;
  logic       rst_n, RX_IN, par_en, strt_glitch, par_err, stp_err;
  logic [5:0] pre_scale;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       data_valid, parity_error, framing_error, busy;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RX_IN         (RX_IN),
    .pre_scale     (pre_scale),
    .par_en        (par_en),
    .strt_glitch   (strt_glitch),
    .par_err       (par_err),
    .stp_err       (stp_err),
    .dat_samp_en   (dat_samp_en),
    .edge_cnt      (edge_cnt),
    .bit_cnt       (bit_cnt),
    .strt_chk_en   (strt_chk_en),
    .deser_en      (deser_en),
    .par_chk_en    (par_chk_en),
    .stp_chk_en    (stp_chk_en),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: active frame, offset k, frame config, captured errors.
  bit m_act  = 1'b0;
  int m_k    = 0;
  int m_ps   = 8;
  bit m_par  = 1'b0;
  bit m_perr = 1'b0;
  bit m_serr = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t, k=%0d)", tag, got, exp, $time, m_k);
    end
  endtask

  function automatic int frame_ps(input logic [5:0] p);
    if (p == 6'd16) return 16;
    if (p == 6'd32) return 32;
    return 8;
  endfunction

  function automatic int ce_of(input int ps);
    return ps / 2 + 2;
  endfunction

  // Offset of the DONE cycle: all full bits, then half-way into stop, plus one.
  function automatic int done_k();
    return m_ps * (DW + 1 + int'(m_par)) + ce_of(m_ps) + 1;
  endfunction

  task automatic start_frame();
    m_act  = 1'b1;
    m_k    = 0;
    m_ps   = frame_ps(pre_scale);
    m_par  = par_en;
    m_perr = 1'b0;
    m_serr = 1'b0;
  endtask

  task automatic compare_outputs();
    int         e_edge, e_bit, ce, b;
    logic [3:0] e_en;
    logic [2:0] e_res;
    logic       e_busy;
    e_edge = 0; e_bit = 0; e_en = '0; e_res = '0; e_busy = 1'b0;
    if (m_act) begin
      e_busy = 1'b1;
      ce = ce_of(m_ps);
      if (m_k == done_k()) begin
        e_res = {!(m_perr || m_serr), m_perr, m_serr};
      end else begin
        e_edge = m_k % m_ps;
        b      = m_k / m_ps;
        e_bit  = b;
        if (e_edge == ce)
          e_en = {b == 0, (b >= 1) && (b <= DW), m_par && (b == DW + 1), b == DW + 1 + int'(m_par)};
      end
    end
    check_val("edge_cnt", 16'(edge_cnt), 16'(e_edge));
    check_val("bit_cnt", 16'(bit_cnt), 16'(e_bit));
    check_val("enables", 16'({strt_chk_en, deser_en, par_chk_en, stp_chk_en}), 16'(e_en));
    check_val("status", 16'({data_valid, parity_error, framing_error}), 16'(e_res));
    check_val("busy_samp", 16'({busy, dat_samp_en}), 16'({e_busy, e_busy}));
  endtask

  // Inputs for the cycle currently in progress (the one the model describes).
  task automatic drive_inputs();
    strt_glitch = ($urandom_range(0, 99) < 20);
    par_err     = ($urandom_range(0, 99) < 25);
    stp_err     = ($urandom_range(0, 99) < 25);
    if (!m_act)                RX_IN = ($urandom_range(0, 9) >= 3);
    else if (m_k == done_k())  RX_IN = ($urandom_range(0, 9) >= 5);
    else                       RX_IN = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 99) < 2) begin
      case ($urandom_range(0, 4))
        0:       pre_scale = 6'd8;
        1:       pre_scale = 6'd16;
        2:       pre_scale = 6'd32;
        3:       pre_scale = 6'($urandom);
        default: pre_scale = 6'd8;
      endcase
      par_en = 1'($urandom_range(0, 1));
    end
  endtask

  // Frame-level rules: start on a low line, abort on a start glitch, capture
  // checker results on their check edges, restart from DONE on a low line.
  task automatic advance_model();
    int ce;
    if (!m_act) begin
      if (!RX_IN) start_frame();
    end else if (m_k == done_k()) begin
      if (!RX_IN) start_frame();
      else        m_act = 1'b0;
    end else begin
      ce = ce_of(m_ps);
      if (m_k == ce && strt_glitch) begin
        m_act = 1'b0;
      end else begin
        if (m_par && m_k == m_ps * (DW + 1) + ce)     m_perr = par_err;
        if (m_k == m_ps * (DW + 1 + int'(m_par)) + ce) m_serr = stp_err;
        m_k++;
      end
    end
  endtask

  initial begin
    int n_rst;
    n_rst       = 0;
    rst_n       = 1'b0;
    RX_IN       = 1'b1;
    pre_scale   = 6'd8;
    par_en      = 1'b1;
    strt_glitch = 1'b0;
    par_err     = 1'b0;
    stp_err     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_outputs();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_inputs();
      advance_model();
      @(posedge clk);
      #1;
      compare_outputs();
      // Abort a frame in the data phase with an asynchronous reset.
      if (n_rst < 2 && cyc > 1500 * (n_rst + 1) && m_act && m_k < done_k() &&
          m_k / m_ps >= 2 && m_k / m_ps <= DW) begin
        #2 rst_n = 1'b0;
        #1;
        m_act = 1'b0;
        compare_outputs();
        @(posedge clk);
        #1;
        compare_outputs();
        rst_n = 1'b1;
        n_rst++;
      end
    end

    if (n_rst < 2) begin
      n_vec++;
      n_err++;
      $display("FAIL reset_inject: got %0d, want %0d", n_rst, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
